// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame sequencer for the convolution output buffer.
// A write phase stores every valid convolution pixel at ascending addresses.
// A read phase then streams the whole buffer out over a valid/ready interface.
// The buffer has a single port, and this block owns it, so the two phases
// never overlap.
module conv_frame_ctrl #(
  parameter int OUT_WIDTH  = 30,
  parameter int OUT_HEIGHT = 30,
  parameter int DEPTH      = OUT_WIDTH * OUT_HEIGHT,
  parameter int AW         = 10,
  parameter int DW         = 48
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          start,
  input  logic          abort,
  input  logic          conv_valid,
  input  logic [DW-1:0] pixel_in,
  output logic          conv_en,
  output logic          buf_we,
  output logic          buf_re,
  output logic [AW-1:0] buf_addr,
  output logic [DW-1:0] buf_wdata,
  input  logic [DW-1:0] buf_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          frame_done,
  output logic          overflow
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_RD_HOLD  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] CNT_ONE   = {{(AW-1){1'b0}}, 1'b1};

  state_t          state_q;
  logic [AW-1:0]   wr_cnt_q;
  logic [AW-1:0]   rd_cnt_q;
  logic [DW-1:0]   out_data_q;
  logic            out_last_q;
  logic            overflow_q;
  logic            wr_fire;

  // Buffer port drive: the write strobe follows conv_valid in WRITE, the read strobe follows RD_ISSUE
  always_comb begin
    wr_fire   = (state_q == S_WRITE) && conv_valid && !abort;
    buf_we    = wr_fire;
    buf_re    = (state_q == S_RD_ISSUE);
    if (wr_fire) begin
      buf_addr  = wr_cnt_q;
      buf_wdata = pixel_in;
    end else if (buf_re) begin
      buf_addr  = rd_cnt_q;
      buf_wdata = {DW{1'b0}};
    end else begin
      buf_addr  = {AW{1'b0}};
      buf_wdata = {DW{1'b0}};
    end
  end

  // Status outputs are pure decodes of the state register
  assign conv_en    = (state_q == S_WRITE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (state_q == S_RD_HOLD);
  assign frame_done = (state_q == S_DONE);
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign overflow   = overflow_q;

  // Frame sequencer: state, address counters, readback beat register and sticky overflow
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q    <= S_IDLE;
      wr_cnt_q   <= {AW{1'b0}};
      rd_cnt_q   <= {AW{1'b0}};
      out_data_q <= {DW{1'b0}};
      out_last_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (abort) begin
      // overflow is deliberately kept so software can still see the error
      state_q    <= S_IDLE;
      wr_cnt_q   <= {AW{1'b0}};
      rd_cnt_q   <= {AW{1'b0}};
      out_data_q <= {DW{1'b0}};
      out_last_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_WRITE;
            wr_cnt_q   <= {AW{1'b0}};
            rd_cnt_q   <= {AW{1'b0}};
            overflow_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (conv_valid) begin
            if (wr_cnt_q == LAST_ADDR) begin
              state_q  <= S_RD_ISSUE;
              rd_cnt_q <= {AW{1'b0}};
            end else begin
              wr_cnt_q <= wr_cnt_q + CNT_ONE;
            end
          end
        end
        S_RD_ISSUE: begin
          state_q <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          out_data_q <= buf_rdata;
          out_last_q <= (rd_cnt_q == LAST_ADDR);
          state_q    <= S_RD_HOLD;
        end
        S_RD_HOLD: begin
          if (out_ready) begin
            out_last_q <= 1'b0;
            if (out_last_q) begin
              state_q <= S_DONE;
            end else begin
              rd_cnt_q <= rd_cnt_q + CNT_ONE;
              state_q  <= S_RD_ISSUE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
      // A pixel arriving outside the write phase is dropped and flagged.
      // Setting the flag after the case means a same-cycle start in IDLE cannot hide it.
      if (conv_valid && (state_q != S_WRITE)) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl. A behavioural single-port RAM sits on the
// buffer port. A scoreboard holds the expected writes and readback beats.
module tb_conv_frame_ctrl;
  localparam int AW    = 10;
  localparam int DW    = 48;
  localparam int DEPTH = 900;

  logic          clk = 1'b0;
  logic          rstb = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          conv_valid = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic          conv_en, buf_we, buf_re;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_wdata, buf_rdata, out_data;
  logic          out_valid, out_last, busy, frame_done, overflow;
  logic          out_ready = 1'b0;

  always #5 clk = ~clk;

  conv_frame_ctrl dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort),
    .conv_valid(conv_valid), .pixel_in(pixel_in), .conv_en(conv_en),
    .buf_we(buf_we), .buf_re(buf_re), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .buf_rdata(buf_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  // Buffer model: synchronous single-port RAM, read data one cycle after buf_re
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] ram_q;
  assign buf_rdata = ram_q;
  always @(posedge clk) begin
    if (buf_we) mem[buf_addr] <= buf_wdata;
    if (buf_re) ram_q <= mem[buf_addr];
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int prev_hs_cyc = 0;
  bit hs_seen = 1'b0;
  bit prev_v = 1'b0;
  bit fixed_ready = 1'b1;
  logic [DW-1:0] prev_data;
  logic prev_last;
  int wq[$];
  int bq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: check port rules, pop the scoreboard on writes and handshakes, and check hold stability
  always @(negedge clk) begin
    int e;
    if (rstb) begin
      prev_v  = 1'b0;
      hs_seen = 1'b0;
    end else begin
      chk("we_re_excl", buf_we & buf_re, 0);
      if (!buf_we && !buf_re) chk("addr_idle", buf_addr, 0);
      if (buf_we) begin
        if (wq.size() == 0) chk("unexp_we", buf_we, 0);
        else begin
          e = wq.pop_front();
          chk("we_addr", buf_addr, e);
          chk("we_data", buf_wdata, e);
        end
      end
      if (prev_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (bq.size() == 0) chk("unexp_beat", out_valid, 0);
        else begin
          e = bq.pop_front();
          chk("beat_data", out_data, e);
          chk("beat_last", out_last, (e == DEPTH - 1));
        end
        if (hs_seen) begin
          if (fixed_ready) chk("beat_gap", cyc - prev_hs_cyc, 3);
          else chk("beat_gap_min", ((cyc - prev_hs_cyc) >= 3), 1);
        end
        hs_seen = 1'b1;
        prev_hs_cyc = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        chk("done_after_last", cyc - prev_hs_cyc, 1);
        hs_seen = 1'b0;
      end
      prev_v    = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  task automatic start_frame();
    for (int i = 0; i < DEPTH; i++) bq.push_back(i);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_conv_en", conv_en, 1);
    chk("start_ovf_clr", overflow, 0);
  endtask

  task automatic do_writes(input int n, input int gapmax, input int start_at);
    for (int i = 0; i < n; i++) begin
      int g;
      @(posedge clk); #1;
      conv_valid = 1'b1;
      pixel_in   = DW'(i);
      start      = (i == start_at);
      wq.push_back(i);
      if (i == DEPTH - 1) begin
        @(negedge clk);
        chk("conv_en_last", conv_en, 1);
      end else if (gapmax > 0) begin
        g = $urandom_range(1, gapmax);
        for (int k = 0; k < g; k++) begin
          @(posedge clk); #1;
          conv_valid = 1'b0;
          start      = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    conv_valid = 1'b0;
    start      = 1'b0;
    if (n == DEPTH) begin
      @(negedge clk);
      chk("conv_en_fall", conv_en, 0);
      chk("busy_rd", busy, 1);
    end
  endtask

  task automatic readback(input bit rnd, input bit pulse_cv);
    int d0 = done_cnt;
    int budget = 0;
    bit pulsed = 1'b0;
    fixed_ready = !rnd;
    while (done_cnt == d0 && budget < 20000) begin
      @(posedge clk); #1;
      out_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      conv_valid = pulse_cv && !pulsed && out_valid;
      if (conv_valid) pulsed = 1'b1;
      budget++;
    end
    conv_valid = 1'b0;
    out_ready  = 1'b0;
    chk("frame_done_seen", done_cnt, d0 + 1);
    chk("beats_all", bq.size(), 0);
    chk("writes_all", wq.size(), 0);
    @(negedge clk);
    chk("done_pulse_1cyc", frame_done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int da;
    int b;
    // Reset state, checked while reset is still asserted
    #12;
    chk("rst_conv_en", conv_en, 0);   chk("rst_we", buf_we, 0);
    chk("rst_re", buf_re, 0);         chk("rst_addr", buf_addr, 0);
    chk("rst_valid", out_valid, 0);   chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);     chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);   chk("rst_ovf", overflow, 0);
    @(posedge clk); #1 rstb = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    // Frame A: back-to-back pixels, downstream always ready
    start_frame();
    do_writes(DEPTH, 0, -1);
    readback(1'b0, 1'b0);
    chk("ovf_A", overflow, 0);

    // Frame B: 1-3 cycle gaps, start ignored mid-write, random ready
    start_frame();
    do_writes(DEPTH, 3, 100);
    readback(1'b1, 1'b0);
    chk("ovf_B", overflow, 0);

    // Pixel in IDLE raises overflow and writes nothing
    @(posedge clk); #1 conv_valid = 1'b1;
    @(posedge clk); #1 conv_valid = 1'b0;
    @(negedge clk);
    chk("ovf_idle", overflow, 1);
    chk("ovf_idle_busy", busy, 0);

    // Frame C: start clears overflow; a pixel during RD_HOLD sets it again
    start_frame();
    do_writes(DEPTH, 0, -1);
    readback(1'b0, 1'b1);
    chk("ovf_sticky", overflow, 1);

    // Abort at wr_cnt=450
    start_frame();
    do_writes(450, 0, -1);
    da = done_cnt;
    abort = 1'b1;
    @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);       chk("abort_conv_en", conv_en, 0);
    chk("abort_we", buf_we, 0);       chk("abort_re", buf_re, 0);
    chk("abort_valid", out_valid, 0); chk("abort_last", out_last, 0);
    chk("abort_done", frame_done, 0);
    bq.delete();
    // abort wins over a same-cycle start
    @(posedge clk); #1 begin abort = 1'b1; start = 1'b1; end
    @(posedge clk); #1 begin abort = 1'b0; start = 1'b0; end
    @(negedge clk);
    chk("abort_over_start", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, da);

    // Frame D: full frame after the abort
    start_frame();
    do_writes(DEPTH, 0, -1);
    readback(1'b0, 1'b0);

    // Asynchronous reset while a beat is held in RD_HOLD
    start_frame();
    do_writes(DEPTH, 0, -1);
    fixed_ready = 1'b1;
    b = 0;
    do begin
      @(posedge clk); #1;
      out_ready = (bq.size() > DEPTH - 5);
      b++;
    end while (!(out_valid && !out_ready && bq.size() == DEPTH - 5) && b < 200);
    chk("reach_hold", out_valid, 1);
    conv_valid = 1'b1;
    @(posedge clk); #1 conv_valid = 1'b0;
    chk("ovf_hold", overflow, 1);
    chk("hold_beat5", out_data, 5);
    #2 rstb = 1'b1;
    #1;
    chk("arst_conv_en", conv_en, 0);   chk("arst_we", buf_we, 0);
    chk("arst_re", buf_re, 0);         chk("arst_addr", buf_addr, 0);
    chk("arst_valid", out_valid, 0);   chk("arst_data", out_data, 0);
    chk("arst_last", out_last, 0);     chk("arst_busy", busy, 0);
    chk("arst_done", frame_done, 0);   chk("arst_ovf", overflow, 0);
    bq.delete();
    @(posedge clk); #1 rstb = 1'b0;
    @(negedge clk);
    chk("after_arst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
